// File: rtl/ram_ctrl_pkg.sv
// Shared constants and state encoding for the 16K x 16 RAM burst sequencer.
// CLEAR exists only when CLEAR_CMD_EN is defined.
package ram_ctrl_pkg;

   localparam int unsigned ADDR_W = 14;
   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
`ifdef CLEAR_CMD_EN
      ,
      CLEAR = 2'd3
`endif
   } state_e;

endpackage : ram_ctrl_pkg

// File: rtl/ram16k_burst_ctrl.sv
// Burst sequencer for the 16K x 16 RAM: one word per cycle, wrapping address, valid/ready streams.
// Optional CLEAR_CMD_EN adds a cmd_clr input that zero-fills a burst without using the write stream.
module ram16k_burst_ctrl #(
   parameter int unsigned LEN_W  = 14,
   parameter int unsigned ADDR_W = ram_ctrl_pkg::ADDR_W,
   parameter int unsigned DATA_W = ram_ctrl_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
`ifdef CLEAR_CMD_EN
   input  logic              cmd_clr,
`endif
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              ram_en,
   output logic              ram_rw,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_in,
   input  logic [DATA_W-1:0] ram_out
);

   import ram_ctrl_pkg::*;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    remain_q, remain_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                advance;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remain_d    = remain_q;
      rd_valid_d  = rd_valid_q;
      rd_data_d   = rd_data_q;
      advance     = 1'b0;
      cmd_ready   = 1'b0;
      wr_ready    = 1'b0;
      ram_en      = 1'b0;
      ram_rw      = 1'b0;
      ram_in      = '0;

      // A taken read word frees the slot; a capture below may refill it in the same cycle.
      if (rd_valid_q && rd_ready) begin
         rd_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d   = cmd_addr;
               remain_d = cmd_len;
`ifdef CLEAR_CMD_EN
               if (cmd_clr) begin
                  state_d = CLEAR;
               end else
`endif
               if (cmd_rw) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end

         WRITE: begin
            wr_ready = 1'b1;
            ram_en   = wr_valid;
            ram_rw   = wr_valid;
            ram_in   = wr_data;
            advance  = wr_valid;
         end

         READ: begin
            ram_en = 1'b1;
            if (!rd_valid_q || rd_ready) begin
               rd_data_d  = ram_out;
               rd_valid_d = 1'b1;
               advance    = 1'b1;
            end
         end

`ifdef CLEAR_CMD_EN
         CLEAR: begin
            ram_en  = 1'b1;
            ram_rw  = 1'b1;
            advance = 1'b1;
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase

      if (advance) begin
         addr_d   = addr_q + ADDR_W'(1);
         remain_d = remain_q - LEN_W'(1);
         if (remain_q == '0) begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign ram_address = addr_q;
   assign busy        = (state_q != IDLE);
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;

endmodule : ram16k_burst_ctrl

// File: tb/tb_ram16k_burst_ctrl.sv
// Directed bench for ram16k_burst_ctrl with a behavioural 16K x 16 RAM attached.
// Define CLEAR_CMD_EN to also exercise the clear command.
module tb_ram16k_burst_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_rw, cmd_clr;
   logic [13:0] cmd_addr, cmd_len;
   logic        wr_valid, wr_ready;
   logic [15:0] wr_data;
   logic        rd_valid, rd_ready;
   logic [15:0] rd_data;
   logic        busy, ram_en, ram_rw;
   logic [13:0] ram_address;
   logic [15:0] ram_in, ram_out;

   logic [15:0] mem [0:16383];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ram16k_burst_ctrl #(.LEN_W(14), .ADDR_W(14), .DATA_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_rw      (cmd_rw),
`ifdef CLEAR_CMD_EN
      .cmd_clr     (cmd_clr),
`endif
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_data     (rd_data),
      .busy        (busy),
      .ram_en      (ram_en),
      .ram_rw      (ram_rw),
      .ram_address (ram_address),
      .ram_in      (ram_in),
      .ram_out     (ram_out)
   );

   // Behavioural RAM: synchronous write, combinational read.
   always @(posedge clk) begin
      if (ram_en && ram_rw) mem[ram_address] = ram_in;
   end
   assign ram_out = mem[ram_address];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Call shortly after a rising edge; returns just after the handshake edge.
   task automatic send_cmd(input logic rw, input logic clr, input logic [13:0] a,
                           input logic [13:0] len);
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_clr   = clr;
      cmd_addr  = a;
      cmd_len   = len;
      #1;
      check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("busy_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic write_burst(input logic [13:0] a, input logic [13:0] len,
                              input logic [15:0] base, input logic [31:0] gaps);
      int n = 0;
      logic [13:0] ea;
      send_cmd(1'b1, 1'b0, a, len);
      for (int c = 0; c < 200 && n <= int'(len); c++) begin
         wr_valid = ~gaps[c % 32];
         wr_data  = base + 16'(n);
         ea       = a + 14'(n);
         #1;
         check("wr_ready", {31'd0, wr_ready}, 32'd1);
         check("wr_addr", {18'd0, ram_address}, {18'd0, ea});
         check("wr_rw", {31'd0, ram_rw}, {31'd0, wr_valid});
         check("wr_en", {31'd0, ram_en}, {31'd0, wr_valid});
         if (wr_valid) begin
            check("wr_in", {16'd0, ram_in}, {16'd0, base + 16'(n)});
            n++;
         end
         @(posedge clk); #1;
      end
      wr_valid = 1'b0;
      #1;
      check("wr_count", n, int'(len) + 1);
      check("wr_end_busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic read_burst(input logic [13:0] a, input logic [13:0] len,
                             input logic [15:0] base, input logic [31:0] rdy_pat);
      int got = 0;
      send_cmd(1'b0, 1'b0, a, len);
      for (int c = 0; c < 200 && got <= int'(len); c++) begin
         rd_ready = rdy_pat[c % 32];
         #1;
         if (c == 0) check("rd_first_lat", {31'd0, rd_valid}, 32'd0);
         if (c == 1) check("rd_first_valid", {31'd0, rd_valid}, 32'd1);
         if (rd_valid) begin
            check("rd_data", {16'd0, rd_data}, {16'd0, base + 16'(got)});
            if (rd_ready) got++;
         end
         @(posedge clk); #1;
      end
      rd_ready = 1'b0;
      #1;
      check("rd_count", got, int'(len) + 1);
      check("rd_end_busy", {31'd0, busy}, 32'd0);
      check("rd_end_valid", {31'd0, rd_valid}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 16'hFFFF;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_clr = 1'b0;
      cmd_addr = '0; cmd_len = '0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_rd_data", {16'd0, rd_data}, 32'd0);
      check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      check("rst_ram_en", {31'd0, ram_en}, 32'd0);
      check("rst_ram_rw", {31'd0, ram_rw}, 32'd0);
      check("rst_ram_addr", {18'd0, ram_address}, 32'd0);
      check("rst_ram_in", {16'd0, ram_in}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

      // Plain 4-word write/read
      write_burst(14'h0010, 14'd3, 16'hA000, 32'h0);
      check("mem_0010", {16'd0, mem[14'h0010]}, 32'hA000);
      check("mem_0013", {16'd0, mem[14'h0013]}, 32'hA003);
      check("mem_0014", {16'd0, mem[14'h0014]}, 32'hFFFF);
      read_burst(14'h0010, 14'd3, 16'hA000, 32'hFFFF_FFFF);

      // Address wrap across the top of the RAM
      write_burst(14'h3FFE, 14'd3, 16'hB000, 32'h0);
      check("mem_3ffe", {16'd0, mem[14'h3FFE]}, 32'hB000);
      check("mem_3fff", {16'd0, mem[14'h3FFF]}, 32'hB001);
      check("mem_0000", {16'd0, mem[14'h0000]}, 32'hB002);
      check("mem_0001", {16'd0, mem[14'h0001]}, 32'hB003);
      read_burst(14'h3FFE, 14'd3, 16'hB000, 32'hFFFF_FFFF);

      // Write with wr_valid gaps, then read back with rd_ready toggling
      write_burst(14'h0400, 14'd7, 16'h7000, 32'h0000_0C12);
      check("mem_0407", {16'd0, mem[14'h0407]}, 32'h7007);
      read_burst(14'h0400, 14'd7, 16'h7000, 32'hAAAA_AAAA);

      // Reset in the middle of a 5-word write, after 2 words
      send_cmd(1'b1, 1'b0, 14'h0200, 14'd4);
      for (int i = 0; i < 2; i++) begin
         wr_valid = 1'b1;
         wr_data  = 16'h5500 + 16'(i);
         @(posedge clk); #1;
      end
      wr_data = 16'h5502;
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_ram_en", {31'd0, ram_en}, 32'd0);
      check("mid_rst_ram_rw", {31'd0, ram_rw}, 32'd0);
      check("mid_rst_addr", {18'd0, ram_address}, 32'd0);
      check("mid_rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_mem_200", {16'd0, mem[14'h0200]}, 32'h5500);
      check("mid_rst_mem_201", {16'd0, mem[14'h0201]}, 32'h5501);
      check("mid_rst_mem_202", {16'd0, mem[14'h0202]}, 32'hFFFF);
      check("mid_rst_mem_204", {16'd0, mem[14'h0204]}, 32'hFFFF);
      check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

`ifdef CLEAR_CMD_EN
      write_burst(14'h0100, 14'd15, 16'hC000, 32'h0);
      send_cmd(1'b1, 1'b1, 14'h0100, 14'd15);
      for (int c = 0; c < 16; c++) begin
         wr_valid = 1'b1;
         #1;
         check("clr_wr_ready", {31'd0, wr_ready}, 32'd0);
         check("clr_ram_rw", {31'd0, ram_rw}, 32'd1);
         check("clr_ram_in", {16'd0, ram_in}, 32'd0);
         check("clr_addr", {18'd0, ram_address}, 32'h100 + 32'(c));
         @(posedge clk); #1;
      end
      wr_valid = 1'b0;
      check("clr_end_busy", {31'd0, busy}, 32'd0);
      read_burst(14'h0100, 14'd15, 16'h0000, 32'hFFFF_FFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got simulation still running expected finished");
      $fatal(1);
   end

endmodule : tb_ram16k_burst_ctrl
